uart_led_driver: RTL and testbench
==================================

// Module: uart_led_driver
// PURPOSE
//  Downstream consumer of the 3-bit Avalon PIO LED register output (out_port).
//  Converts the raw register bits into physical LED drive for the EP2C5 board.
//  Each LED is pulse-stretched so that brief software writes remain visible.
//  All LEDs are then dimmed by a global PWM brightness, with a lamp-test override.
//  Sits between the PIO register and the LED pins, in the same clock domain.
// PARAMETERS
//  PWM_BITS        8          PWM counter and brightness width
//  STRETCH_CYCLES  5000000    minimum lit time per rising edge (100 ms @ 50 MHz); 0 = no stretch
//  ACTIVE_LOW      1          1: LED on = pin 0; 0: LED on = pin 1
// PORTS
//  clk          in   1          system clock; single clock domain
//  reset        in   1          asynchronous, active-high reset
//  led_req      in   3          LED request bits from the PIO out_port
//  brightness   in   PWM_BITS   global duty: 0 = off, 2^PWM_BITS-1 = always on
//  lamp_test    in   1          1: force all LEDs fully on
//  led_out      out  3          registered LED pin drive (polarity set by ACTIVE_LOW)
//  lit          out  3          pre-PWM logical on state per LED (status/readback)
// BEHAVIOUR
//  Reset (async, active-high):
//   - req_q, stretch counters and pwm_cnt are cleared to 0.
//   - lit = 0.
//   - led_out = all-off: 3'b111 if ACTIVE_LOW, else 3'b000.
//   - Reset asserted mid-stretch aborts the stretch; no LED resumes after release.
//  Input stage:
//   - req_q <= led_req every cycle.
//   - rise[i] = led_req[i] & ~req_q[i], evaluated on the pre-edge values.
//  Stretch counter (one per LED, width $clog2(STRETCH_CYCLES+1)):
//   - On rise[i]: load STRETCH_CYCLES. A reload wins over a decrement (retrigger).
//   - Otherwise, if nonzero: decrement by 1. Holds at 0.
//  lit[i] = req_q[i] | (cnt[i] != 0), combinational from registers.
//   - A 1-cycle request keeps lit high for exactly STRETCH_CYCLES cycles after the sampling edge.
//   - A longer request keeps lit high for max(request length, STRETCH_CYCLES) cycles from the rising edge.
//   - With STRETCH_CYCLES = 0, lit == req_q.
//  PWM:
//   - pwm_cnt is free-running, 0 .. 2^PWM_BITS-2, then wraps to 0 (period 2^PWM_BITS-1).
//   - pwm_on = (pwm_cnt < brightness).
//   - brightness = 0 gives 0 % duty; brightness = 2^PWM_BITS-1 gives 100 % duty.
//   - brightness is sampled live, with no shadow register; a change takes effect at the next compare.
//  Output register:
//   - on_i = lamp_test | (lit[i] & pwm_on).
//   - led_out[i] <= ACTIVE_LOW ? ~on_i : on_i.
//  Latency:
//   - led_req rise to led_out change: 2 clk (req_q edge, then output edge), provided pwm_on.
//   - lamp_test assert/deassert to led_out: 1 clk.
//   - lamp_test never disturbs the counters or lit; it only overrides led_out.
//  Simultaneous events:
//   - A rise on several LEDs in one cycle: each loads independently.
//   - A rise while the counter is nonzero: reload.
//   - A fall of led_req while counting: the counter continues.
// TESTING
//  T1 reset: STRETCH=10, start a stretch on LED0, assert reset async mid-count
//     -> led_out = 3'b111 and lit = 0 without waiting for a clock edge;
//     -> after release with led_req = 0, both stay off.
//  T2 pulse: STRETCH=10, brightness=255, led_req[0] high for 1 clk at edge E1
//     -> lit[0] high for exactly 10 cycles;
//     -> led_out[0] = 0 from edge E2 through E11, then 1.
//  T3 retrigger: STRETCH=10, LED1 pulsed at E1, pulsed again at E6
//     -> lit[1] held continuously until 10 cycles after E6.
//  T4 PWM duty: led_req = 3'b111 steady, brightness = 64
//     -> each led_out bit is on for exactly 64 of every 255 cycles;
//     -> brightness = 0 gives never on; brightness = 255 gives always on.
//  T5 lamp test: led_req = 0, brightness = 0, lamp_test = 1
//     -> led_out = 3'b000 one clk later;
//     -> on deassert, led_out = 3'b111 one clk later.
//  T6 no stretch: STRETCH_CYCLES = 0, random led_req with brightness = 255
//     -> lit equals led_req delayed by 1 clk;
//     -> led_out equals ~led_req delayed by 2 clk.

Source files
------------

// File: rtl/uart_led_driver.sv
// uart_led_driver
// Turns the 3-bit PIO LED register into LED pin drive for the EP2C5 board.
// A short software write to the register would light an LED too briefly to
// see, so each request is pulse-stretched to a minimum lit time. The lit
// LEDs are then dimmed by a shared PWM brightness. Lamp test forces every
// LED fully on without touching the stretch or PWM state.
//
// Ports
//   clk         system clock (single domain, shared with the PIO register)
//   reset       asynchronous, active-high reset
//   led_req     LED request bits from the PIO out_port
//   brightness  global duty: 0 = off, all-ones = always on
//   lamp_test   1 forces all LEDs on at the pins
//   led_out     registered pin drive, polarity set by ACTIVE_LOW
//   lit         logical on state per LED before PWM (status readback)
module uart_led_driver #(
  parameter int PWM_BITS       = 8,
  parameter int STRETCH_CYCLES = 5000000,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          led_req,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                lamp_test,
  output logic [2:0]          led_out,
  output logic [2:0]          lit
);

  // A zero stretch still needs a 1-bit counter so the vectors stay legal;
  // it is only ever loaded with 0, so lit collapses to req_q.
  localparam int CNT_W = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);
  // The PWM counter stops one short of all-ones so that a brightness of
  // all-ones is strictly greater than every count, giving 100 % duty.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [2:0]          LED_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [2:0]                 req_q;
  logic [2:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [2:0]                 led_out_q, led_out_d;
  logic [2:0]                 rise;
  logic                       pwm_on;
  logic [2:0]                 on;

  // Edge detect and stretch counters. A rising request always reloads the
  // full stretch, even mid-count, so a retrigger extends the lit time; a
  // falling request leaves the counter running down on its own.
  always_comb begin
    rise  = led_req & ~req_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (rise[i]) begin
        cnt_d[i] = STRETCH_LOAD;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // An LED is logically on while its request is held or its stretch is
  // still running; both terms come straight from registers.
  always_comb begin
    lit = '0;
    for (int i = 0; i < 3; i++) begin
      lit[i] = req_q[i] | (cnt_q[i] != '0);
    end
  end

  // Free-running PWM counter; brightness is compared live with no shadow
  // register, so a new value takes effect on the very next compare.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (pwm_cnt_q < brightness);
  end

  // Pin drive: lamp test wins over everything, otherwise lit gated by PWM,
  // then flipped to the board's pin polarity.
  always_comb begin
    on        = {3{lamp_test}} | (lit & {3{pwm_on}});
    led_out_d = ACTIVE_LOW ? ~on : on;
  end

  // All state is cleared asynchronously so a reset mid-stretch drops the
  // LEDs immediately and nothing resumes after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= '0;
      cnt_q     <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= LED_OFF;
    end else begin
      req_q     <= led_req;
      cnt_q     <= cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_uart_led_driver.sv
// tb_uart_led_driver
// Directed bench for uart_led_driver. Instance A runs with a 10-cycle
// stretch for reset, pulse, retrigger, PWM duty and lamp-test steps;
// instance B runs with no stretch and random requests. Expected values are
// pushed to queues as stimulus is driven and popped when the outputs are
// sampled one time unit after each rising clock edge.
module tb_uart_led_driver;

  localparam int STRETCH = 10;

  typedef struct packed {
    logic [2:0] expLit;
    logic [2:0] expLed;
  } expEntry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] reqA, reqB;
  logic [7:0] brightA, brightB;
  logic       lampA, lampB;
  logic [2:0] ledOutA, ledOutB;
  logic [2:0] litA, litB;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  expEntry_t  scoreQ[$];
  logic [2:0] litQ[$];
  logic [2:0] ledQ[$];
  int         dutyQ[$];

  uart_led_driver #(
    .PWM_BITS(8),
    .STRETCH_CYCLES(STRETCH),
    .ACTIVE_LOW(1'b1)
  ) dutA (
    .clk(clk),
    .reset(reset),
    .led_req(reqA),
    .brightness(brightA),
    .lamp_test(lampA),
    .led_out(ledOutA),
    .lit(litA)
  );

  uart_led_driver #(
    .PWM_BITS(8),
    .STRETCH_CYCLES(0),
    .ACTIVE_LOW(1'b1)
  ) dutB (
    .clk(clk),
    .reset(reset),
    .led_req(reqB),
    .brightness(brightB),
    .lamp_test(lampB),
    .led_out(ledOutB),
    .lit(litB)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard stop in case something stalls the directed sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses ledMask on instance A for one cycle at every edge k whose bit is
  // set in pulseEdges. Expected lit: on for STRETCH cycles counted from the
  // most recent sampling edge. Expected pins: last cycle's lit, inverted.
  task automatic applyStimulus(input string tag, input logic [2:0] ledMask,
                               input logic [31:0] pulseEdges, input int numEdges);
    logic      prevOn;
    logic      curOn;
    int        lastPulse;
    expEntry_t e;
    prevOn    = 1'b0;
    lastPulse = -100;
    for (int k = 1; k <= numEdges; k++) begin
      reqA = pulseEdges[k] ? ledMask : 3'b000;
      if (pulseEdges[k]) lastPulse = k;
      curOn    = (k - lastPulse) < STRETCH;
      e.expLit = curOn ? ledMask : 3'b000;
      e.expLed = prevOn ? ~ledMask : 3'b111;
      scoreQ.push_back(e);
      prevOn = curOn;
      tick();
      e = scoreQ.pop_front();
      checkOutput({tag, " lit"}, int'(litA), int'(e.expLit));
      checkOutput({tag, " led_out"}, int'(ledOutA), int'(e.expLed));
    end
    reqA = 3'b000;
  endtask

  initial begin
    int         onCount[3];
    int         expDuty;
    logic [2:0] r;
    logic [7:0] duties[4];
    duties = '{8'd64, 8'd0, 8'd255, 8'd1};

    reset   = 1'b1;
    reqA    = 3'b000;
    reqB    = 3'b000;
    brightA = 8'd255;
    brightB = 8'd255;
    lampA   = 1'b0;
    lampB   = 1'b0;

    // Reset state of both instances.
    repeat (2) tick();
    checkOutput("reset led_out A", int'(ledOutA), 3'b111);
    checkOutput("reset lit A", int'(litA), 3'b000);
    checkOutput("reset led_out B", int'(ledOutB), 3'b111);
    reset = 1'b0;
    tick();

    // T1: start a stretch on LED0, then reset asynchronously mid-count.
    reqA = 3'b001;
    tick();
    reqA = 3'b000;
    repeat (2) tick();
    checkOutput("T1 stretching lit", int'(litA), 3'b001);
    checkOutput("T1 stretching led_out", int'(ledOutA), 3'b110);
    #3 reset = 1'b1;
    #1;
    checkOutput("T1 async led_out", int'(ledOutA), 3'b111);
    checkOutput("T1 async lit", int'(litA), 3'b000);
    #1 reset = 1'b0;
    tick();
    checkOutput("T1 post-release lit", int'(litA), 3'b000);
    repeat (STRETCH + 2) tick();
    checkOutput("T1 no resume lit", int'(litA), 3'b000);
    checkOutput("T1 no resume led_out", int'(ledOutA), 3'b111);

    // T2: single-cycle pulse on LED0 sampled at edge 1.
    applyStimulus("T2", 3'b001, 32'h0000_0002, 14);

    // T3: LED1 pulsed at edges 1 and 6; the second pulse reloads.
    applyStimulus("T3", 3'b010, 32'h0000_0042, 18);

    // T4: steady requests, count on-cycles over one full PWM period.
    reqA = 3'b111;
    for (int d = 0; d < 4; d++) begin
      brightA = duties[d];
      dutyQ.push_back(int'(duties[d]));
      repeat (2) tick();
      for (int i = 0; i < 3; i++) onCount[i] = 0;
      repeat (255) begin
        tick();
        for (int i = 0; i < 3; i++) if (ledOutA[i] == 1'b0) onCount[i]++;
      end
      expDuty = dutyQ.pop_front();
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("T4 duty b=%0d led%0d", expDuty, i), onCount[i], expDuty);
      end
    end

    // T5: lamp test with nothing lit and zero brightness.
    reqA    = 3'b000;
    brightA = 8'd0;
    repeat (STRETCH + 3) tick();
    checkOutput("T5 idle led_out", int'(ledOutA), 3'b111);
    lampA = 1'b1;
    tick();
    checkOutput("T5 lamp on led_out", int'(ledOutA), 3'b000);
    checkOutput("T5 lamp on lit", int'(litA), 3'b000);
    lampA = 1'b0;
    tick();
    checkOutput("T5 lamp off led_out", int'(ledOutA), 3'b111);

    // T6: no stretch; lit follows led_req by 1 clk, pins by 2 clk inverted.
    ledQ.push_back(3'b111);
    for (int n = 0; n < 40; n++) begin
      r    = 3'($urandom_range(0, 7));
      reqB = r;
      litQ.push_back(r);
      ledQ.push_back(~r);
      tick();
      checkOutput("T6 lit", int'(litB), int'(litQ.pop_front()));
      checkOutput("T6 led_out", int'(ledOutB), int'(ledQ.pop_front()));
    end
    reqB = 3'b000;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
